// File: rtl/stopwatch_pkg.sv
// Shared constants and BCD digit helpers for the stopwatch timekeeping core.
package stopwatch_pkg;

   localparam logic MODE_UP   = 1'b0;
   localparam logic MODE_DOWN = 1'b1;
   localparam logic SEL_SEC   = 1'b0;
   localparam logic SEL_MIN   = 1'b1;

   localparam logic [3:0] BCD_DIG_MAX = 4'd9;
   localparam logic [3:0] BCD_TEN_MAX = 4'd5;

   // Returns {carry, digit}; the digit wraps to 0 past max.
   function automatic logic [4:0] bcd_inc(input logic [3:0] d, input logic [3:0] max);
      if (d >= max) return {1'b1, 4'd0};
      else          return {1'b0, d + 4'd1};
   endfunction

   // Returns {borrow, digit}; the digit wraps to max below 0.
   function automatic logic [4:0] bcd_dec(input logic [3:0] d, input logic [3:0] max);
      if (d == 4'd0) return {1'b1, max};
      else           return {1'b0, d - 4'd1};
   endfunction

   function automatic logic [3:0] bcd_clamp(input logic [3:0] d, input logic [3:0] max);
      return (d > max) ? max : d;
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Clock-enable divider: registered one-cycle tick every DIV clocks, realignable by restart.
module tick_gen #(
   parameter int unsigned DIV = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] r_cnt;
   logic          r_tick;
   logic [CW-1:0] w_cnt_nxt;

   assign w_cnt_nxt = (restart || (r_cnt == LAST)) ? '0 : r_cnt + CW'(1);

   // Tick is registered from the next count so it is high while the count sits at LAST.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt  <= '0;
         r_tick <= 1'b0;
      end else begin
         r_cnt  <= w_cnt_nxt;
         r_tick <= (w_cnt_nxt == LAST);
      end
   end

   assign tick = r_tick;

endmodule

// File: rtl/stopwatch_core.sv
// BCD mm:ss up/down stopwatch core with preset load, countdown expiry and adjust mode.
// Lap capture is built only when STOPWATCH_LAP_EN is defined.
module stopwatch_core
   import stopwatch_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 100_000_000,
   parameter int unsigned ADJ_HZ     = 2,
   parameter int unsigned MIN_DIGITS = 2,
   parameter int unsigned WRAP       = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    pause_p,
   input  logic                    adj,
   input  logic                    sel,
   input  logic                    mode,
   input  logic                    load,
   input  logic [4*MIN_DIGITS-1:0] preset_min,
   input  logic [7:0]              preset_sec,
   input  logic                    lap_p,
   output logic [4*MIN_DIGITS-1:0] minutes,
   output logic [7:0]              seconds,
   output logic                    running,
   output logic                    expired,
   output logic                    lap_valid,
   output logic [4*MIN_DIGITS-1:0] lap_min,
   output logic [7:0]              lap_sec
);

   localparam int unsigned MW      = 4 * MIN_DIGITS;
   localparam int unsigned ADJ_DIV = (CLK_HZ / ADJ_HZ > 0) ? CLK_HZ / ADJ_HZ : 1;

   logic [MW-1:0] r_min;
   logic [7:0]    r_sec;
   logic          r_running;
   logic          r_expired;
   logic          r_adj_d;

   logic          w_cnt_tick;
   logic          w_adj_tick;
   logic [7:0]    w_sec_inc;
   logic [7:0]    w_sec_dec;
   logic          w_sec_cy;
   logic          w_sec_bw;
   logic [MW-1:0] w_min_inc;
   logic [MW-1:0] w_min_dec;
   logic          w_min_cy;
   logic [MW-1:0] w_pre_min;
   logic [7:0]    w_pre_sec;
   logic          w_at_zero;
   logic          w_pause_ok;
   logic          w_start;

   assign w_at_zero  = (r_min == '0) && (r_sec == 8'h00);
   assign w_pause_ok = pause_p && !load && !adj && !((mode == MODE_DOWN) && w_at_zero);
   assign w_start    = w_pause_ok && !r_running;

   tick_gen #(.DIV(CLK_HZ)) u_cnt_tick (
      .clk     (clk),
      .rst     (rst),
      .restart (w_start),
      .tick    (w_cnt_tick)
   );

   // Realigned on entry to adjust mode so the first step is a full period away.
   tick_gen #(.DIV(ADJ_DIV)) u_adj_tick (
      .clk     (clk),
      .rst     (rst),
      .restart (adj && !r_adj_d),
      .tick    (w_adj_tick)
   );

   always_comb begin
      logic [4:0] v_lo;
      logic [4:0] v_hi;
      v_lo      = bcd_inc(r_sec[3:0], BCD_DIG_MAX);
      v_hi      = v_lo[4] ? bcd_inc(r_sec[7:4], BCD_TEN_MAX) : {1'b0, r_sec[7:4]};
      w_sec_inc = {v_hi[3:0], v_lo[3:0]};
      w_sec_cy  = v_hi[4];
      v_lo      = bcd_dec(r_sec[3:0], BCD_DIG_MAX);
      v_hi      = v_lo[4] ? bcd_dec(r_sec[7:4], BCD_TEN_MAX) : {1'b0, r_sec[7:4]};
      w_sec_dec = {v_hi[3:0], v_lo[3:0]};
      w_sec_bw  = v_hi[4];
   end

   // Ripple carry/borrow across minute digits; all-nines carries out to zero.
   always_comb begin
      logic       v_c;
      logic       v_b;
      logic [4:0] v_r;
      w_min_inc = r_min;
      w_min_dec = r_min;
      v_c       = 1'b1;
      v_b       = 1'b1;
      v_r       = '0;
      for (int i = 0; i < MIN_DIGITS; i++) begin
         if (v_c) begin
            v_r                 = bcd_inc(r_min[4*i +: 4], BCD_DIG_MAX);
            w_min_inc[4*i +: 4] = v_r[3:0];
            v_c                 = v_r[4];
         end
         if (v_b) begin
            v_r                 = bcd_dec(r_min[4*i +: 4], BCD_DIG_MAX);
            w_min_dec[4*i +: 4] = v_r[3:0];
            v_b                 = v_r[4];
         end
      end
      w_min_cy = v_c;
   end

   always_comb begin
      w_pre_min = '0;
      for (int i = 0; i < MIN_DIGITS; i++)
         w_pre_min[4*i +: 4] = bcd_clamp(preset_min[4*i +: 4], BCD_DIG_MAX);
      w_pre_sec = {bcd_clamp(preset_sec[7:4], BCD_TEN_MAX), bcd_clamp(preset_sec[3:0], BCD_DIG_MAX)};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_min     <= '0;
         r_sec     <= '0;
         r_running <= 1'b0;
         r_expired <= 1'b0;
         r_adj_d   <= 1'b0;
      end else begin
         r_adj_d <= adj;
         if (load) begin
            r_min     <= w_pre_min;
            r_sec     <= w_pre_sec;
            r_running <= 1'b0;
            r_expired <= 1'b0;
         end else if (adj) begin
            r_running <= 1'b0;
            if (w_adj_tick && r_adj_d) begin
               if (sel == SEL_SEC) r_sec <= w_sec_inc;
               else                r_min <= w_min_inc;
            end
         end else begin
            if (w_pause_ok) begin
               r_running <= !r_running;
               if (!r_running) r_expired <= 1'b0;
            end
            // Step decisions use the pre-toggle running and override the toggle when they stop.
            if (r_running && w_cnt_tick) begin
               if (mode == MODE_UP) begin
                  if (w_sec_cy && w_min_cy && (WRAP == 0)) begin
                     r_running <= 1'b0;
                  end else begin
                     r_sec <= w_sec_inc;
                     if (w_sec_cy) r_min <= w_min_inc;
                  end
               end else if (w_at_zero) begin
                  r_expired <= 1'b1;
                  r_running <= 1'b0;
               end else begin
                  r_sec <= w_sec_dec;
                  if (w_sec_bw) r_min <= w_min_dec;
                  if ((r_min == '0) && (r_sec == 8'h01)) begin
                     r_expired <= 1'b1;
                     r_running <= 1'b0;
                  end
               end
            end
         end
      end
   end

   assign minutes = r_min;
   assign seconds = r_sec;
   assign running = r_running;
   assign expired = r_expired;

`ifdef STOPWATCH_LAP_EN
   logic          r_lap_valid;
   logic [MW-1:0] r_lap_min;
   logic [7:0]    r_lap_sec;

   always_ff @(posedge clk) begin
      if (rst || load) begin
         r_lap_valid <= 1'b0;
         r_lap_min   <= '0;
         r_lap_sec   <= '0;
      end else if (lap_p) begin
         r_lap_valid <= 1'b1;
         r_lap_min   <= r_min;
         r_lap_sec   <= r_sec;
      end
   end

   assign lap_valid = r_lap_valid;
   assign lap_min   = r_lap_min;
   assign lap_sec   = r_lap_sec;
`else
   logic w_unused_lap;
   assign w_unused_lap = lap_p;
   assign lap_valid    = 1'b0;
   assign lap_min      = '0;
   assign lap_sec      = '0;
`endif

endmodule
